// File: rtl/gray_conv_arbiter_pkg.sv
// Shared types and sizing for the Gray-to-binary arbiter: FSM state encoding,
// default requester count, code width and requester-index width.
package gray_conv_arbiter_pkg;

  localparam int GCA_N_REQ = 4;
  localparam int GCA_W     = 4;
  localparam int ID_W      = 2;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/gray_conv_arbiter_gray2bin.sv
// Combinational W-bit Gray-to-binary converter: bit k of the result is the XOR of
// Gray bits W-1 down to k, which unrolls B[W-1]=G[W-1], B[k]=B[k+1]^G[k].
module gray2bin_w #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  // Each bit reduces the shifted Gray input directly, so bin_o never feeds back on itself.
  always_comb begin
    bin_o = '0;
    for (int k = 0; k < W; k++) begin
      bin_o[k] = ^(gray_i >> k);
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Arbitrates N_REQ requesters onto one shared Gray-to-binary converter (IDLE/CONV/RESP).
// Define GRAY_ARB_RR_EN for round-robin grants; otherwise the lowest index wins.
module gray_conv_arbiter
  import gray_conv_arbiter_pkg::*;
#(
  parameter int N_REQ = GCA_N_REQ,
  parameter int W     = GCA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_gray,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  output logic [W-1:0]       rsp_bin,
  output logic [ID_W-1:0]    rsp_id,
  input  logic               rsp_ready,
  output logic [CNT_W-1:0]   conv_cnt
);

  state_t            state_q, state_d;
  logic [W-1:0]      gray_q, gray_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [W-1:0]      rsp_bin_q, rsp_bin_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]      conv_bin;
  logic [ID_W-1:0]   grant_idx;
  logic              any_req;

  assign any_req = |req_valid;

`ifdef GRAY_ARB_RR_EN
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] scan_idx;
  logic            found;

  // Search begins at the pointer and wraps naturally through the ID_W-bit index.
  always_comb begin
    grant_idx = '0;
    scan_idx  = '0;
    found     = 1'b0;
    for (int o = 0; o < N_REQ; o++) begin
      scan_idx = ptr_q + ID_W'(o);
      if (!found && req_valid[scan_idx]) begin
        grant_idx = scan_idx;
        found     = 1'b1;
      end
    end
  end
`else
  always_comb begin
    grant_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) grant_idx = ID_W'(i);
    end
  end
`endif

  gray2bin_w #(.W(W)) u_gray2bin (
    .gray_i (gray_q),
    .bin_o  (conv_bin)
  );

  always_comb begin
    // NOTE: every signal written here gets its hold value first, so no path can infer a latch.
    state_d     = state_q;
    gray_d      = gray_q;
    id_d        = id_q;
    rsp_bin_d   = rsp_bin_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    cnt_d       = cnt_q;
    req_ready   = '0;
`ifdef GRAY_ARB_RR_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          // Strobe suppressed while reset is held, since the FSM is parked in IDLE then.
          if (!rst) req_ready[grant_idx] = 1'b1;
          gray_d  = req_gray[grant_idx*W +: W];
          id_d    = grant_idx;
          state_d = CONV;
`ifdef GRAY_ARB_RR_EN
          ptr_d   = grant_idx + ID_W'(1);
`endif
        end
      end
      CONV: begin
        rsp_bin_d   = conv_bin;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cnt_d       = cnt_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gray_q      <= '0;
      id_q        <= '0;
      rsp_bin_q   <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gray_q      <= gray_d;
      id_q        <= id_d;
      rsp_bin_q   <= rsp_bin_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef GRAY_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  assign rsp_valid = rsp_valid_q;
  assign rsp_bin   = rsp_bin_q;
  assign rsp_id    = rsp_id_q;
  assign conv_cnt  = cnt_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter: table-driven conversions plus hand-written
// sequences for backpressure, arbitration, reset in flight and counter wrap.
module tb_gray_conv_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_gray;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [3:0]  rsp_bin;
  logic [1:0]  rsp_id;
  logic        rsp_ready;
  logic [7:0]  conv_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_cnt = 8'd0;

  typedef struct packed {
    logic [1:0] slot;
    logic [3:0] gray;
    logic [3:0] bin;
  } vec_t;

  vec_t vecs[20];

  gray_conv_arbiter #(.N_REQ(4), .W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_gray  (req_gray),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_bin   (rsp_bin),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .conv_cnt  (conv_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'b0000;
    #1;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_cnt", 32'(conv_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 8'd0;
  endtask

  // One request on a single slot; the slot data is corrupted right after acceptance.
  task automatic do_conv(input logic [1:0] slot, input logic [3:0] gray,
                         input logic [3:0] exp_bin, input int hold);
    @(negedge clk);
    req_valid = 4'b0001 << slot;
    req_gray  = 16'h0000;
    req_gray[int'(slot)*4 +: 4] = gray;
    rsp_ready = 1'b1;
    #1 check("accept_ready", 32'(req_ready), 32'(4'b0001 << slot));
    @(negedge clk);
    req_valid = 4'b0000;
    req_gray  = ~req_gray;
    rsp_ready = (hold == 0);
    #1;
    check("conv_ready", 32'(req_ready), 32'd0);
    check("conv_valid", 32'(rsp_valid), 32'd0);
    check("conv_cnt_ignored", 32'(conv_cnt), 32'(exp_cnt));
    @(negedge clk);
    #1;
    check("resp_valid", 32'(rsp_valid), 32'd1);
    check("resp_bin", 32'(rsp_bin), 32'(exp_bin));
    check("resp_id", 32'(rsp_id), 32'(slot));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_bin", 32'(rsp_bin), 32'(exp_bin));
      check("hold_id", 32'(rsp_id), 32'(slot));
      check("hold_cnt", 32'(conv_cnt), 32'(exp_cnt));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    exp_cnt = exp_cnt + 8'd1;
    #1;
    check("done_valid", 32'(rsp_valid), 32'd0);
    check("done_cnt", 32'(conv_cnt), 32'(exp_cnt));
  endtask

  initial begin
    logic [1:0] exp_ids[4];
    logic [3:0] arb_bins[4];

    vecs[0]  = '{2'd0, 4'b0000, 4'b0000};
    vecs[1]  = '{2'd0, 4'b0001, 4'b0001};
    vecs[2]  = '{2'd0, 4'b0010, 4'b0011};
    vecs[3]  = '{2'd0, 4'b0011, 4'b0010};
    vecs[4]  = '{2'd0, 4'b0100, 4'b0111};
    vecs[5]  = '{2'd0, 4'b0101, 4'b0110};
    vecs[6]  = '{2'd0, 4'b0110, 4'b0100};
    vecs[7]  = '{2'd0, 4'b0111, 4'b0101};
    vecs[8]  = '{2'd0, 4'b1000, 4'b1111};
    vecs[9]  = '{2'd0, 4'b1001, 4'b1110};
    vecs[10] = '{2'd0, 4'b1010, 4'b1100};
    vecs[11] = '{2'd0, 4'b1011, 4'b1101};
    vecs[12] = '{2'd0, 4'b1100, 4'b1000};
    vecs[13] = '{2'd0, 4'b1101, 4'b1001};
    vecs[14] = '{2'd0, 4'b1110, 4'b1011};
    vecs[15] = '{2'd0, 4'b1111, 4'b1010};
    vecs[16] = '{2'd1, 4'b0101, 4'b0110};
    vecs[17] = '{2'd2, 4'b0110, 4'b0100};
    vecs[18] = '{2'd3, 4'b1111, 4'b1010};
    vecs[19] = '{2'd3, 4'b1000, 4'b1111};

`ifdef GRAY_ARB_RR_EN
    exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3};
`else
    exp_ids = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
    arb_bins = '{4'b0001, 4'b0010, 4'b0101, 4'b1010};

    rst = 1'b0;
    req_valid = 4'b1111;
    req_gray  = 16'h0000;
    rsp_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("por_ready", 32'(req_ready), 32'd0);
    check("por_valid", 32'(rsp_valid), 32'd0);
    check("por_bin", 32'(rsp_bin), 32'd0);
    check("por_id", 32'(rsp_id), 32'd0);
    check("por_cnt", 32'(conv_cnt), 32'd0);
    @(negedge clk);
    req_valid = 4'b0000;
    rst = 1'b0;

    // Single request and backpressure.
    do_conv(2'd0, 4'b1011, 4'b1101, 0);
    do_conv(2'd2, 4'b0110, 4'b0100, 4);

    // Exhaustive slot-0 sweep plus other slots.
    for (int v = 0; v < 20; v++) begin
      do_conv(vecs[v].slot, vecs[v].gray, vecs[v].bin, 0);
    end

    // Reset while in CONV discards the conversion.
    do_reset();
    @(negedge clk);
    req_valid = 4'b1000;
    req_gray  = 16'h8000;
    rsp_ready = 1'b1;
    #1 check("rc_accept", 32'(req_ready), 32'b1000);
    @(negedge clk);
    req_valid = 4'b0000;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 check("rc_no_valid", 32'(rsp_valid), 32'd0);
    end
    check("rc_cnt", 32'(conv_cnt), 32'd0);
    req_valid = 4'b0001;
    #1 check("rc_idle", 32'(req_ready), 32'b0001);
    req_valid = 4'b0000;

    // Arbitration with all four requesters held.
    do_reset();
    @(negedge clk);
    req_valid = 4'b1111;
    req_gray  = {4'b1111, 4'b0111, 4'b0011, 4'b0001};
    rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c % 3 == 0) check("arb_grant", 32'(req_ready), 32'(4'b0001 << exp_ids[c/3]));
      if (c % 3 == 2) begin
        check("arb_valid", 32'(rsp_valid), 32'd1);
        check("arb_id", 32'(rsp_id), 32'(exp_ids[c/3]));
        check("arb_bin", 32'(rsp_bin), 32'(arb_bins[exp_ids[c/3]]));
      end
      @(negedge clk);
    end
    req_valid = 4'b0000;
    #1 check("arb_cnt", 32'(conv_cnt), 32'd4);

    // 256 back-to-back conversions wrap the counter.
    do_reset();
    @(negedge clk);
    req_valid = 4'b0001;
    req_gray  = 16'h0000;
    rsp_ready = 1'b1;
    #1;
    for (int k = 1; k <= 256; k++) begin
      int t;
      t = 0;
      while (rsp_valid !== 1'b1 && t < 6) begin
        @(negedge clk);
        #1;
        t++;
      end
      if (t >= 6) begin
        check("wrap_timeout", 32'd1, 32'd0);
        break;
      end
      @(negedge clk);
      #1;
      if (k == 255) check("wrap_255", 32'(conv_cnt), 32'd255);
      if (k == 256) check("wrap_0", 32'(conv_cnt), 32'd0);
    end
    req_valid = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
